// File: rtl/rc_cpl_sink_if.sv
// rc_cpl_sink_if: aligned RC payload beats plus the per-TLP
// completion descriptor coming from the realignment stage.
interface rc_cpl_sink_if;
  logic         rc_valid;
  logic         rc_sop;
  logic         rc_eop;
  logic [255:0] rc_data;
  logic [7:0]   rc_keep;
  logic         rc_desc_valid;
  logic [7:0]   rc_tag;
  logic [2:0]   rc_status;
  logic [10:0]  rc_dword_count;
  logic [12:0]  rc_byte_count;
  logic         rc_request_completed;

  modport master (
    output rc_valid, rc_sop, rc_eop, rc_data, rc_keep,
    output rc_desc_valid, rc_tag, rc_status,
    output rc_dword_count, rc_byte_count, rc_request_completed
  );

  modport slave (
    input rc_valid, rc_sop, rc_eop, rc_data, rc_keep,
    input rc_desc_valid, rc_tag, rc_status,
    input rc_dword_count, rc_byte_count, rc_request_completed
  );
endinterface

// File: rtl/rc_cpl_sink.sv
// rc_cpl_sink: consumes aligned RC completions, writes payload into
// per-tag destination buffers and reports finished read requests.
module rc_cpl_sink #(
  parameter int NUM_TAGS = 32,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  rc_cpl_sink_if.slave      rc,
  input  logic              alloc_valid,
  input  logic [7:0]        alloc_tag,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [255:0]      wr_data,
  output logic [31:0]       wr_be,
  output logic              done_valid,
  output logic [7:0]        done_tag,
  output logic              done_err,
  output logic              unexp_err,
  output logic              align_err,
  output logic              proto_err,
  output logic [5:0]        outstanding
);
  localparam int         TW = $clog2(NUM_TAGS);
  localparam logic [8:0] NT = 9'(NUM_TAGS);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_e;

  state_e state_q, state_d, e_mode, d_mode;

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [ADDR_W-1:0]   ptr_q [NUM_TAGS];
  logic [ADDR_W-1:0]   ptr_d [NUM_TAGS];

  logic [7:0] tag_q, e_tag;
  logic [2:0] st_q, e_st;
  logic       cmpl_q, e_cmpl;
  logic       hit_q, e_hit, d_hit;

  logic [TW-1:0] e_idx, a_idx;
  logic          beat_wr, tlp_end, alloc_ok;

  logic              alloc_err_q, alloc_err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [255:0]      wr_data_q, wr_data_d;
  logic [31:0]       wr_be_q, wr_be_d;
  logic              done_q, done_d;
  logic [7:0]        done_tag_q, done_tag_d;
  logic              done_err_q, done_err_d;
  logic              unexp_q, unexp_d;
  logic              align_q, align_d;
  logic              proto_q, proto_d;
  logic [5:0]        cnt_q, cnt_d;

  logic unused_ok;
  assign unused_ok = ^{rc.rc_sop, rc.rc_dword_count, rc.rc_byte_count};

  // A new descriptor overrides the latched context in its own cycle
  always_comb begin
    d_hit  = ({1'b0, rc.rc_tag} < NT) && busy_q[rc.rc_tag[TW-1:0]];
    d_mode = (d_hit && rc.rc_status == 3'd0) ? DATA : DROP;
    if (rc.rc_desc_valid) begin
      e_mode = d_mode;
      e_tag  = rc.rc_tag;
      e_st   = rc.rc_status;
      e_cmpl = rc.rc_request_completed;
      e_hit  = d_hit;
    end else begin
      e_mode = state_q;
      e_tag  = tag_q;
      e_st   = st_q;
      e_cmpl = cmpl_q;
      e_hit  = hit_q;
    end
  end

  assign e_idx = e_tag[TW-1:0];
  assign a_idx = alloc_tag[TW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = e_mode;
    if (rc.rc_valid && rc.rc_eop) state_d = IDLE;
  end

  always_comb begin
    beat_wr    = rc.rc_valid && (e_mode == DATA);
    tlp_end    = rc.rc_valid && rc.rc_eop && (e_mode != IDLE);
    wr_en_d    = beat_wr;
    wr_addr_d  = beat_wr ? ptr_q[e_idx] : '0;
    wr_data_d  = beat_wr ? rc.rc_data : '0;
    wr_be_d    = '0;
    for (int i = 0; i < 8; i++)
      wr_be_d[4*i +: 4] = {4{beat_wr & rc.rc_keep[i]}};
    done_d     = tlp_end && e_cmpl && e_hit;
    done_tag_d = done_d ? e_tag : '0;
    done_err_d = done_d && (e_st != 3'd0);
    align_d    = beat_wr && rc.rc_eop && !e_cmpl
                 && (rc.rc_keep != 8'hFF);
    unexp_d    = rc.rc_desc_valid && !d_hit;
    proto_d    = (rc.rc_desc_valid && state_q != IDLE)
                 || (rc.rc_valid && e_mode == IDLE);
  end

  // Allocation checks the pre-free busy bit, so a tag being freed stays refused
  always_comb begin
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    alloc_ok    = alloc_valid && ({1'b0, alloc_tag} < NT)
                  && !busy_q[a_idx];
    alloc_err_d = alloc_valid && !alloc_ok;
    if (beat_wr) ptr_d[e_idx] = ptr_q[e_idx] + ADDR_W'(1);
    if (done_d)  busy_d[e_idx] = 1'b0;
    if (alloc_ok) begin
      busy_d[a_idx] = 1'b1;
      ptr_d[a_idx]  = alloc_addr;
    end
    cnt_d = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      cnt_d = cnt_d + 6'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) ptr_q[i] <= '0;
      tag_q       <= '0;
      st_q        <= '0;
      cmpl_q      <= 1'b0;
      hit_q       <= 1'b0;
      alloc_err_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
      done_q      <= 1'b0;
      done_tag_q  <= '0;
      done_err_q  <= 1'b0;
      unexp_q     <= 1'b0;
      align_q     <= 1'b0;
      proto_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      tag_q       <= e_tag;
      st_q        <= e_st;
      cmpl_q      <= e_cmpl;
      hit_q       <= e_hit;
      alloc_err_q <= alloc_err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_be_q     <= wr_be_d;
      done_q      <= done_d;
      done_tag_q  <= done_tag_d;
      done_err_q  <= done_err_d;
      unexp_q     <= unexp_d;
      align_q     <= align_d;
      proto_q     <= proto_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alloc_err   = alloc_err_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_be       = wr_be_q;
  assign done_valid  = done_q;
  assign done_tag    = done_tag_q;
  assign done_err    = done_err_q;
  assign unexp_err   = unexp_q;
  assign align_err   = align_q;
  assign proto_err   = proto_q;
  assign outstanding = cnt_q;
endmodule
